// File: rtl/datamem_dma_pkg.sv
// Shared types and default widths for the datamem_dma block-copy engine.
package datamem_dma_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/datamem_dma.sv
// Word-by-word block copy engine driving a single-port data memory.
// Optional running checksum of copied words when DATAMEM_DMA_CHECKSUM_EN is defined.
module datamem_dma
  import datamem_dma_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output state_t            fsm_state
`ifdef DATAMEM_DMA_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  // Memory handshake: the memory has no ready; a strobe is serviced in the
  // cycle it is raised (read data combinational, write committed on the edge).

  state_t            state, state_next;
  logic [ADDR_W-1:0] src, dst, remaining;
  logic [DATA_W-1:0] buffer;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      buffer    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start && (length != '0)) begin
            src       <= src_addr;
            dst       <= dst_addr;
            remaining <= length;
          end
        end
        READ:  buffer <= mem_read_data;
        WRITE: begin
          src       <= src + 1'b1;
          dst       <= dst + 1'b1;
          remaining <= remaining - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DATAMEM_DMA_CHECKSUM_EN
  // Cleared on any accepted start, including a zero-length one.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (state == WRITE) begin
      checksum <= checksum + buffer;
    end
  end
`endif

  always_comb begin
    state_next       = state;
    busy             = 1'b1;
    done             = 1'b0;
    mem_address      = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        mem_address     = src;
        mem_read_enable = 1'b1;
        state_next      = WRITE;
      end
      WRITE: begin
        mem_address      = dst;
        mem_write_enable = 1'b1;
        mem_write_data   = buffer;
        state_next       = (remaining == 1) ? DONE : READ;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_datamem_dma.sv
// Directed bench for datamem_dma paired with a behavioural single-port data memory.
module tb_datamem_dma;
  import datamem_dma_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW-1:0] length = '0;
  logic          busy, done;
  logic [AW-1:0] mem_address;
  logic          mem_read_enable, mem_write_enable;
  logic [DW-1:0] mem_write_data, mem_read_data;
  state_t        fsm_state;
`ifdef DATAMEM_DMA_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  datamem_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .mem_address      (mem_address),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .fsm_state        (fsm_state)
`ifdef DATAMEM_DMA_CHECKSUM_EN
    ,
    .checksum         (checksum)
`endif
  );

  // Clock and data memory
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign mem_read_data = mem_read_enable ? mem[mem_address] : '0;
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_write_data;
  end

  // Scoreboard
  int n_cmp = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic verify_mem(input string tag, input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      check($sformatf("%s[%0h]", tag, a), 32'(mem[a]), 32'(exp_q.pop_front()));
    end
  endtask

  // Driver: issue a start and monitor until done (bounded).
  int done_cyc, n_rd, n_wr, strobe_err, busy_err, busy_after;

  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW-1:0] n, input bit mid_start);
    int cyc;
    done_cyc = -1; n_rd = 0; n_wr = 0; strobe_err = 0; busy_err = 0;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; length = n;
    cyc = 0;
    while (cyc < 60 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (mid_start && cyc >= 3) begin
        start = 1'b1; src_addr = 16'h0010; dst_addr = 16'h0300; length = 16'd2;
      end else begin
        start = 1'b0;
      end
      if (mem_read_enable) n_rd++;
      if (mem_write_enable) n_wr++;
      if (mem_read_enable && mem_write_enable) strobe_err++;
      if (!mem_read_enable && !mem_write_enable && mem_address != '0) strobe_err++;
      if (!mem_write_enable && mem_write_data != '0) strobe_err++;
      if (done && (mem_read_enable || mem_write_enable)) strobe_err++;
      if (!busy) busy_err++;
      if (done) done_cyc = cyc;
    end
    @(negedge clk);
    start = 1'b0;
    busy_after = int'(busy);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(mem_address), 0);
    check("rst_re", 32'(mem_read_enable), 0);
    check("rst_we", 32'(mem_write_enable), 0);
    check("rst_wdata", 32'(mem_write_data), 0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));

    // Scenario 1: 4-word copy
    mem[16'h0010] = 16'd1; mem[16'h0011] = 16'd2;
    mem[16'h0012] = 16'd3; mem[16'h0013] = 16'd4;
    run_copy(16'h0010, 16'h0100, 16'd4, 1'b0);
    check("s1_done_cyc", 32'(done_cyc), 9);
    check("s1_reads", 32'(n_rd), 4);
    check("s1_writes", 32'(n_wr), 4);
    check("s1_strobes", 32'(strobe_err), 0);
    check("s1_busy", 32'(busy_err), 0);
    check("s1_busy_after", 32'(busy_after), 0);
    exp_q.push_back(16'd1); exp_q.push_back(16'd2);
    exp_q.push_back(16'd3); exp_q.push_back(16'd4);
    verify_mem("s1_mem", 16'h0100, 4);
`ifdef DATAMEM_DMA_CHECKSUM_EN
    check("s1_csum", 32'(checksum), 32'h000A);
`endif

    // Scenario 2: zero length
    run_copy(16'h0010, 16'h0180, 16'd0, 1'b0);
    check("s2_done_cyc", 32'(done_cyc), 1);
    check("s2_reads", 32'(n_rd), 0);
    check("s2_writes", 32'(n_wr), 0);
    check("s2_strobes", 32'(strobe_err), 0);
    exp_q.push_back(16'd0);
    verify_mem("s2_mem", 16'h0180, 1);
`ifdef DATAMEM_DMA_CHECKSUM_EN
    check("s2_csum", 32'(checksum), 32'h0000);
`endif

    // Scenario 3: source address wraps
    mem[16'hFFFF] = 16'hAAAA; mem[16'h0000] = 16'hBBBB;
    run_copy(16'hFFFF, 16'h0200, 16'd2, 1'b0);
    check("s3_done_cyc", 32'(done_cyc), 5);
    check("s3_strobes", 32'(strobe_err), 0);
    exp_q.push_back(16'hAAAA); exp_q.push_back(16'hBBBB);
    verify_mem("s3_mem", 16'h0200, 2);
`ifdef DATAMEM_DMA_CHECKSUM_EN
    check("s3_csum", 32'(checksum), 32'h6665);
`endif

    // Scenario 4: reset during WRITE of word 2
    begin
      int bad_we, bad_done;
      mem[16'h0050] = 16'h0101; mem[16'h0051] = 16'h0202;
      mem[16'h0052] = 16'h0303; mem[16'h0053] = 16'h0404;
      @(negedge clk);
      start = 1'b1; src_addr = 16'h0050; dst_addr = 16'h0150; length = 16'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("s4_in_write", 32'(fsm_state), 32'(WRITE));
      check("s4_write_addr", 32'(mem_address), 32'h0151);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("s4_busy", 32'(busy), 0);
      check("s4_done", 32'(done), 0);
      check("s4_we", 32'(mem_write_enable), 0);
      check("s4_re", 32'(mem_read_enable), 0);
      check("s4_addr", 32'(mem_address), 0);
      bad_we = 0; bad_done = 0;
      repeat (10) begin
        @(negedge clk);
        if (mem_write_enable) bad_we++;
        if (done) bad_done++;
      end
      check("s4_no_we", 32'(bad_we), 0);
      check("s4_no_done", 32'(bad_done), 0);
      exp_q.push_back(16'h0101); exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
      verify_mem("s4_mem", 16'h0150, 1);
      verify_mem("s4_mem", 16'h0152, 2);
    end

    // Scenario 5: start pulsed mid-transfer and on the done cycle
    mem[16'h0040] = 16'h0011; mem[16'h0041] = 16'h0022;
    mem[16'h0042] = 16'h0033; mem[16'h0043] = 16'h0044;
    run_copy(16'h0040, 16'h0140, 16'd4, 1'b1);
    check("s5_done_cyc", 32'(done_cyc), 9);
    check("s5_writes", 32'(n_wr), 4);
    check("s5_busy_after", 32'(busy_after), 0);
    exp_q.push_back(16'h0011); exp_q.push_back(16'h0022);
    exp_q.push_back(16'h0033); exp_q.push_back(16'h0044);
    verify_mem("s5_mem", 16'h0140, 4);
    exp_q.push_back(16'h0000);
    verify_mem("s5_alt", 16'h0300, 1);
`ifdef DATAMEM_DMA_CHECKSUM_EN
    check("s5_csum", 32'(checksum), 32'h00AA);
`endif

    // Scenario 6: overlapping forward copy replicates the pattern
    mem[16'h0020] = 16'h0005;
    run_copy(16'h0020, 16'h0021, 16'd3, 1'b0);
    check("s6_done_cyc", 32'(done_cyc), 7);
    exp_q.push_back(16'h0005); exp_q.push_back(16'h0005); exp_q.push_back(16'h0005);
    verify_mem("s6_mem", 16'h0021, 3);
`ifdef DATAMEM_DMA_CHECKSUM_EN
    check("s6_csum", 32'(checksum), 32'h000F);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
